tinytpu_result_serializer: RTL and testbench



---
 rtl/tinytpu_result_serializer.sv | 155 +++++++++++++++
 tb/tb_tinytpu_result_serializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tinytpu_result_serializer.sv
// tinytpu_result_serializer: captures one N*N result tile and shifts it out MSB-first on data_out_z.
// Optional per-word even parity bit: define TINYTPU_SER_PARITY_EN.
module tinytpu_result_serializer #(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int ACC_W = 2*D_W + $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   res_valid,
  input  logic [N*N*ACC_W-1:0]   res_data,
  output logic                   res_ready,
  input  logic                   tx_hold,
  output logic                   data_out_z,
  output logic                   tx_ready,
  output logic                   tx_done
);

  // state | meaning
  // IDLE  | waiting for a tile; res_ready high
  // SHIFT | emitting word bits; word_q/bit_q point at the next bit to emit
  // PAR   | emitting the even-parity bit of word_q (parity build only)
  // DONE  | tx_done pulse cycle, then back to IDLE

  localparam int NW     = N*N;
  localparam int WORD_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int BIT_W  = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NW-1);
  localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(ACC_W-1);
  localparam logic [BIT_W-1:0]  SECOND_BIT = BIT_W'(ACC_W-2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef TINYTPU_SER_PARITY_EN
    , PAR = 2'd3
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [NW*ACC_W-1:0]    shadow_q, shadow_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   last_q, last_d;
  logic                   data_out_z_q, data_out_z_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   tx_done_q, tx_done_d;
  logic [ACC_W-1:0]       cur_word;

  assign res_ready  = (state_q == IDLE);
  assign data_out_z = data_out_z_q;
  assign tx_ready   = tx_ready_q;
  assign tx_done    = tx_done_q;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    word_d       = word_q;
    bit_d        = bit_q;
    last_d       = last_q;
    data_out_z_d = data_out_z_q;
    tx_ready_d   = 1'b0;
    tx_done_d    = 1'b0;
    cur_word     = shadow_q[int'(word_q)*ACC_W +: ACC_W];

    case (state_q)
      IDLE: begin
        if (res_valid) begin
          // Word 0 MSB goes out on the capture edge so it is visible in the next cycle.
          shadow_d     = res_data;
          word_d       = '0;
          bit_d        = SECOND_BIT;
          last_d       = 1'b0;
          data_out_z_d = res_data[ACC_W-1];
          tx_ready_d   = 1'b1;
          state_d      = SHIFT;
        end
      end

      SHIFT: begin
        if (!tx_hold) begin
          if (last_q) begin
            tx_done_d = 1'b1;
            state_d   = DONE;
          end else begin
            data_out_z_d = cur_word[bit_q];
            tx_ready_d   = 1'b1;
            if (bit_q != '0) begin
              bit_d = bit_q - 1'b1;
            end else begin
`ifdef TINYTPU_SER_PARITY_EN
              state_d = PAR;
`else
              if (word_q == LAST_WORD) begin
                last_d = 1'b1;
              end else begin
                word_d = word_q + 1'b1;
                bit_d  = TOP_BIT;
              end
`endif
            end
          end
        end
      end

`ifdef TINYTPU_SER_PARITY_EN
      PAR: begin
        if (!tx_hold) begin
          data_out_z_d = ^cur_word;
          tx_ready_d   = 1'b1;
          state_d      = SHIFT;
          if (word_q == LAST_WORD) begin
            last_d = 1'b1;
          end else begin
            word_d = word_q + 1'b1;
            bit_d  = TOP_BIT;
          end
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      word_q       <= '0;
      bit_q        <= '0;
      last_q       <= 1'b0;
      data_out_z_q <= 1'b0;
      tx_ready_q   <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      word_q       <= word_d;
      bit_q        <= bit_d;
      last_q       <= last_d;
      data_out_z_q <= data_out_z_d;
      tx_ready_q   <= tx_ready_d;
      tx_done_q    <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_tinytpu_result_serializer.sv
// Scoreboard bench for tinytpu_result_serializer: randomized and directed tiles against a frame-level model.
`timescale 1ns/1ps
module tb_tinytpu_result_serializer;

  localparam int D_W   = 8;
  localparam int N     = 2;
  localparam int ACC_W = 17;
  localparam int NW    = N*N;
  localparam int TW    = NW*ACC_W;
`ifdef TINYTPU_SER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int PER_WORD  = ACC_W + PAR_BITS;
  localparam int FRAME_LEN = NW*PER_WORD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          res_valid = 1'b0;
  logic [TW-1:0] res_data = '0;
  logic          tx_hold = 1'b0;
  logic          res_ready, data_out_z, tx_ready, tx_done;

  tinytpu_result_serializer #(.D_W(D_W), .N(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .tx_hold(tx_hold), .data_out_z(data_out_z),
    .tx_ready(tx_ready), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Frame bit idx of a tile: word-major, MSB first, optional even-parity bit after each word.
  function automatic int model_bit(input logic [TW-1:0] tile, input int idx);
    int k, pos;
    logic [ACC_W-1:0] w;
    k   = idx / PER_WORD;
    pos = idx % PER_WORD;
    w   = tile[k*ACC_W +: ACC_W];
    if (pos < ACC_W) return int'(w[ACC_W-1-pos]);
    return $countones(w) % 2;
  endfunction

  function automatic logic [TW-1:0] pack(input int w0, input int w1, input int w2, input int w3);
    logic [TW-1:0] t;
    t = '0;
    t[0*ACC_W +: ACC_W] = w0[ACC_W-1:0];
    t[1*ACC_W +: ACC_W] = w1[ACC_W-1:0];
    t[2*ACC_W +: ACC_W] = w2[ACC_W-1:0];
    t[3*ACC_W +: ACC_W] = w3[ACC_W-1:0];
    return t;
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int i = 0; i < TW; i++) t[i] = 1'($urandom_range(0, 1));
    return t;
  endfunction

  typedef struct {
    int first_cyc;
    int done_cyc;
    int nbits;
  } frame_t;

  int     exp_bits[$];
  frame_t frames[$];

  // Monitor: pops the expected bit stream on every valid bit, checks frame timing on tx_done.
  int got_bits = 0;
  int rr_high  = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        got_bits = 0;
        rr_high  = 0;
      end else begin
        if (tx_ready) begin
          if (exp_bits.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_bit: got tx_ready=1 data=%0b with no frame pending (cycle %0d)", data_out_z, cyc);
          end else begin
            if (got_bits == 0 && frames.size() > 0)
              check("first_bit_cycle", 64'(cyc), 64'(frames[0].first_cyc));
            check($sformatf("frame_bit%0d", got_bits), 64'(data_out_z), 64'(exp_bits.pop_front()));
            got_bits++;
            if (res_ready) rr_high++;
          end
        end
        if (tx_done) begin
          check("done_without_ready", 64'(tx_ready), 64'd0);
          if (frames.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got tx_done=1 with no frame pending (cycle %0d)", cyc);
          end else begin
            frame_t f;
            f = frames.pop_front();
            check("done_cycle", 64'(cyc), 64'(f.done_cyc));
            check("frame_len", 64'(got_bits), 64'(f.nbits));
            check("res_ready_low_in_frame", 64'(rr_high), 64'd0);
          end
          got_bits = 0;
          rr_high  = 0;
        end
      end
    end
  end

  task automatic send_tile(input logic [TW-1:0] tile, input int hold_at, input int hold_len,
                           input bit keep_valid, output int h);
    int waited;
    frame_t f;
    int frozen;
    waited    = 0;
    res_data  = tile;
    res_valid = 1'b1;
    while (!res_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 3000) begin
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: got res_ready=0 for %0d cycles, required 1", waited);
        res_valid = 1'b0;
        h = -1;
        return;
      end
    end
    h = cyc + 1;
    for (int i = 0; i < FRAME_LEN; i++) exp_bits.push_back(model_bit(tile, i));
    f.first_cyc = h;
    f.done_cyc  = h + FRAME_LEN + hold_len;
    f.nbits     = FRAME_LEN;
    frames.push_back(f);
    @(posedge clk);
    #1;
    if (!keep_valid) res_valid = 1'b0;
    res_data = rand_tile();
    if (hold_len > 0) begin
      do @(negedge clk); while (cyc < h + hold_at - 1);
      tx_hold = 1'b1;
      frozen  = model_bit(tile, hold_at - 1);
      repeat (hold_len) begin
        @(negedge clk);
        check("hold_tx_ready", 64'(tx_ready), 64'd0);
        check("hold_data_frozen", 64'(data_out_z), 64'(frozen));
      end
      tx_hold = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (frames.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain_frames_left", 64'(frames.size()), 64'd0);
    check("drain_bits_left", 64'(exp_bits.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h1, h2, ha, hl;
    logic [TW-1:0] t;

    // Reset with res_valid asserted: outputs stay quiet, nothing captured.
    rst_n     = 1'b0;
    res_valid = 1'b1;
    res_data  = rand_tile();
    repeat (4) begin
      @(negedge clk);
      check("rst_data_out_z", 64'(data_out_z), 64'd0);
      check("rst_tx_ready", 64'(tx_ready), 64'd0);
      check("rst_tx_done", 64'(tx_done), 64'd0);
    end
    res_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("res_ready_after_reset", 64'(res_ready), 64'd1);
    repeat (3) @(negedge clk);

    // Directed tile from the datasheet example.
    send_tile(pack(32'h10001, 32'h00003, 32'h1FFFF, 32'h00000), 0, 0, 1'b0, h1);
    drain();

    // Same tile, hold for 3 cycles where frame bit 5 would go out.
    send_tile(pack(32'h10001, 32'h00003, 32'h1FFFF, 32'h00000), 5, 3, 1'b0, h1);
    drain();

    // Back-to-back with res_valid held high across both tiles.
    send_tile(pack(32'h0AAAA, 32'h15555, 32'h00001, 32'h10000), 0, 0, 1'b1, ha);
    send_tile(pack(32'h1FFFE, 32'h00002, 32'h12345, 32'h0F0F0), 0, 0, 1'b0, h2);
    check("b2b_second_handshake", 64'(h2), 64'(ha + FRAME_LEN + 2));
    drain();

    // Randomized tiles with occasional holds and idle gaps.
    for (int r = 0; r < 8; r++) begin
      t = rand_tile();
      if ($urandom_range(0, 1) == 1)
        send_tile(t, int'($urandom_range(1, FRAME_LEN - 1)), int'($urandom_range(1, 4)), 1'b0, h1);
      else
        send_tile(t, 0, 0, 1'b0, h1);
      drain();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a frame at bit 20.
    send_tile(rand_tile(), 0, 0, 1'b0, hl);
    while (cyc < hl + 20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_bits.delete();
    frames.delete();
    #1;
    check("midrst_data_out_z", 64'(data_out_z), 64'd0);
    check("midrst_tx_ready", 64'(tx_ready), 64'd0);
    check("midrst_tx_done", 64'(tx_done), 64'd0);
    check("midrst_res_ready", 64'(res_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_tile(pack(32'h1FFFF, 32'h10000, 32'h00001, 32'h0AAAA), 0, 0, 1'b0, h1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
